simon_core_n: RTL
=================

Name: simon_core_n

Overview:
- Parametrised next-generation Simon game controller: generic pattern width, generic sequence depth, and a WIN mode on filling the sequence memory.
- Runs entirely on one system clock. Player button presses arrive as a synchronous single-cycle `step` strobe, produced by an upstream debouncer/edge detector; there is no separate button clock.
- Drives the pattern LEDs, mode LEDs and a score count to the board top level.

Parameters:
- WIDTH, 4: pattern/switch width in bits; at least 2.
- DEPTH, 64: maximum sequence length (memory entries); at least 2; need not be a power of two.
- LW, $clog2(DEPTH+1): width of the length/score counter (derived localparam).

Ports:
- clk, input, 1: system clock; all state changes on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- step, input, 1: advance/commit strobe; acts on every cycle it is high.
- level, input, 1: 0 = any pattern valid; 1 = pattern must be one-hot.
- pattern, input, WIDTH: player switches.
- pattern_leds, output, WIDTH: displayed pattern.
- mode_leds, output, 3: mode indicator.
- score, output, LW: number of stored sequence entries.

Behaviour:
- State:
  - mode register: INPUT, PLAYBACK, REPEAT, DONE, WIN.
  - len counter (0..DEPTH) and idx pointer (0..DEPTH-1).
  - mem: DEPTH x WIDTH, not reset.
- Reset (rst_n low, asynchronous, at any time including mid-round):
  - mode = INPUT, len = 0, idx = 0.
  - Outputs during reset: mode_leds = 3'b001, score = 0, pattern_leds = pattern.
- mode_leds (combinational from mode): INPUT 3'b001, PLAYBACK 3'b010, REPEAT 3'b100, DONE 3'b111, WIN 3'b101.
- pattern_leds (combinational, zero latency): equals pattern in INPUT and REPEAT; equals mem[idx] in PLAYBACK, DONE and WIN.
- score = len at all times.
- Validity check: level is sampled on the step cycle in INPUT.
  - level = 1: valid only if pattern has exactly one bit set.
  - level = 0: every pattern is valid, including all-zero.
- INPUT, step:
  - Valid pattern: mem[len] <= pattern, len <= len+1, idx <= 0, go to PLAYBACK.
  - Invalid pattern: no state change.
- PLAYBACK, step:
  - idx == len-1: idx <= 0, go to REPEAT.
  - Otherwise: idx <= idx+1.
- REPEAT, step, pattern == mem[idx]:
  - idx != len-1: idx <= idx+1.
  - idx == len-1 and len == DEPTH: idx <= 0, go to WIN.
  - idx == len-1 and len < DEPTH: idx <= 0, go to INPUT.
- REPEAT, step, pattern != mem[idx]: idx <= 0, go to DONE.
- DONE / WIN, step: idx <= (idx == len-1) ? 0 : idx+1, i.e. endless review of the sequence. Only reset leaves these modes.
- step low: all registers hold. level and pattern changes affect only the combinational displays.
- No other step/reset interaction: reset dominates; a step in the same cycle as reset deassertion is ignored only if it precedes the first rising edge after deassertion.
- len never exceeds DEPTH, because an INPUT commit is unreachable when len == DEPTH. Arithmetic on idx/len is unsigned LW-bit with no overflow.
- Memory write and read use the same clk. A write in cycle N is visible on pattern_leds in PLAYBACK from cycle N+1.

Test Plan:
- WIDTH=4, DEPTH=64. Reset, then pattern=0001, step.
  - Required: mode_leds 010, pattern_leds 0001, score 1.
  - Then step: mode_leds 100.
  - Then pattern=0001, step: mode_leds 001.
- Level gating: in INPUT with len=1, level=1.
  - pattern=1010, step: mode_leds stays 001, score stays 1.
  - pattern=1000, step: mode_leds 010.
  - Playback shows 0001, then after step 1000, then after step mode_leds 100.
- Failed repeat and review: sequence {0001,1000}. Enter 0001 (stays REPEAT), then 0100.
  - Required: mode_leds 111, pattern_leds 0001.
  - Successive steps show 1000, 0001 (wrap); mode stays 111.
- Win: WIDTH=4, DEPTH=2, level=0. Complete two full rounds with correct repeats.
  - Required: after the final correct guess, mode_leds 101, score 2, pattern_leds cycles mem[0], mem[1].
- Async reset mid-PLAYBACK (len=2, idx=1): pull rst_n low between clock edges.
  - Required, immediately without a clock: mode_leds 001, score 0, pattern_leds = pattern.
- Level 0 accepts zero: level=0, pattern=0000, step.
  - Required: mode_leds 010, pattern_leds 0000, score 1.

Source files
------------

// File: rtl/simon_core_n.sv
// Simon game controller. It stores a growing sequence of switch patterns,
// plays them back, and checks the player's repeat of them. It ends in a
// review loop on a miss (DONE) or once the sequence memory is full (WIN).
module simon_core_n #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 64,
   localparam int LW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             step,
   input  logic             level,
   input  logic [WIDTH-1:0] pattern,
   output logic [WIDTH-1:0] pattern_leds,
   output logic [2:0]       mode_leds,
   output logic [LW-1:0]    score
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [LW-1:0] ONE   = LW'(1);
   localparam logic [LW-1:0] ZERO  = '0;
   localparam logic [LW-1:0] FULL  = LW'(DEPTH);

   typedef enum logic [2:0] {
      INPUT    = 3'd0,
      PLAYBACK = 3'd1,
      REPEAT   = 3'd2,
      DONE     = 3'd3,
      WIN      = 3'd4
   } mode_t;

   mode_t           mode;
   logic [LW-1:0]   len;
   logic [LW-1:0]   idx;
   logic [WIDTH-1:0] mem [0:DEPTH-1];

   logic [AW-1:0]    rd_addr;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] mem_rd;
   logic             at_last;
   logic             pattern_ok;
   logic             commit;

   assign rd_addr    = idx[AW-1:0];
   assign wr_addr    = len[AW-1:0];
   assign mem_rd     = mem[rd_addr];
   assign at_last    = (idx == len - ONE);
   assign pattern_ok = !level || $onehot(pattern);
   assign commit     = step && (mode == INPUT) && pattern_ok;

   // The memory is not reset; only entries below len are ever read.
   always_ff @(posedge clk) begin
      if (commit)
         mem[wr_addr] <= pattern;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode <= INPUT;
         len  <= ZERO;
         idx  <= ZERO;
      end else if (step) begin
         case (mode)
            INPUT: begin
               if (pattern_ok) begin
                  len  <= len + ONE;
                  idx  <= ZERO;
                  mode <= PLAYBACK;
               end
            end
            PLAYBACK: begin
               if (at_last) begin
                  idx  <= ZERO;
                  mode <= REPEAT;
               end else begin
                  idx <= idx + ONE;
               end
            end
            REPEAT: begin
               if (pattern != mem_rd) begin
                  idx  <= ZERO;
                  mode <= DONE;
               end else if (!at_last) begin
                  idx <= idx + ONE;
               end else begin
                  idx  <= ZERO;
                  mode <= (len == FULL) ? WIN : INPUT;
               end
            end
            DONE, WIN: begin
               idx <= at_last ? ZERO : idx + ONE;
            end
            default: begin
               mode <= INPUT;
               idx  <= ZERO;
            end
         endcase
      end
   end

   always_comb begin
      mode_leds    = 3'b001;
      pattern_leds = pattern;
      case (mode)
         INPUT:    mode_leds = 3'b001;
         PLAYBACK: begin
            mode_leds    = 3'b010;
            pattern_leds = mem_rd;
         end
         REPEAT:   mode_leds = 3'b100;
         DONE: begin
            mode_leds    = 3'b111;
            pattern_leds = mem_rd;
         end
         WIN: begin
            mode_leds    = 3'b101;
            pattern_leds = mem_rd;
         end
         default:  mode_leds = 3'b001;
      endcase
   end

   assign score = len;

endmodule
